// File: rtl/bvh_leaf_emitter_if.sv
// ============================================================================
// Module   : bvh_leaf_emitter_if
// Purpose  : Bundle for the node-test and primitive-group FIFO connections
//            of the BVH leaf emitter.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface bvh_leaf_emitter_if #(
    parameter int NODE_INDEX_WIDTH  = 8,
    parameter int PRIM_INDEX_WIDTH  = 10,
    parameter int PRIM_AMOUNT_WIDTH = 4
);
    logic                                   start;
    logic                                   node_req;
    logic [NODE_INDEX_WIDTH-1:0]            node_idx;
    logic                                   node_valid;
    logic [1:0]                             child_hit;
    logic [1:0]                             child_leaf;
    logic [1:0][NODE_INDEX_WIDTH-1:0]       child_node;
    logic [1:0][PRIM_INDEX_WIDTH-1:0]       child_start;
    logic [1:0][PRIM_AMOUNT_WIDTH-1:0]      child_num;
    logic                                   fifo_reset;
    logic                                   push;
    logic [1:0][PRIM_INDEX_WIDTH-1:0]       start_prim;
    logic [1:0][PRIM_AMOUNT_WIDTH-1:0]      num_prim;
    logic                                   busy;
    logic                                   done;
    logic                                   overflow;

    // Emitter side: consumes node-test responses, produces requests and pushes.
    modport master (
        input  start, node_valid, child_hit, child_leaf,
               child_node, child_start, child_num,
        output node_req, node_idx, fifo_reset, push,
               start_prim, num_prim, busy, done, overflow
    );

    modport slave (
        output start, node_valid, child_hit, child_leaf,
               child_node, child_start, child_num,
        input  node_req, node_idx, fifo_reset, push,
               start_prim, num_prim, busy, done, overflow
    );
endinterface

`default_nettype wire

// File: rtl/bvh_leaf_emitter.sv
// ============================================================================
// Module   : bvh_leaf_emitter
// Purpose  : Depth-first BVH walker that pushes hit leaf primitive ranges
//            onto the primitive-group FIFO, one node per node-test response.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bvh_leaf_emitter #(
    parameter int NODE_INDEX_WIDTH  = 8,
    parameter int PRIM_INDEX_WIDTH  = 10,
    parameter int PRIM_AMOUNT_WIDTH = 4,
    parameter int STACK_DEPTH       = 16,
    parameter int ROOT_NODE         = 0
) (
    input  wire                  clk,
    input  wire                  resetn,
    bvh_leaf_emitter_if.master   bus
);

    localparam int c_AW = $clog2(STACK_DEPTH);
    localparam int c_PW = c_AW + 1;
    localparam logic [c_PW-1:0] c_SP_FULL = c_PW'(STACK_DEPTH);
    localparam logic [NODE_INDEX_WIDTH-1:0] c_ROOT = NODE_INDEX_WIDTH'(ROOT_NODE);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_WAIT = 1'b1;

    logic [0:0]                          r_state;
    logic [c_PW-1:0]                     r_sp;
    logic [NODE_INDEX_WIDTH-1:0]         r_stack [STACK_DEPTH];

    logic                                r_node_req;
    logic [NODE_INDEX_WIDTH-1:0]         r_node_idx;
    logic                                r_fifo_reset;
    logic                                r_push;
    logic [1:0][PRIM_INDEX_WIDTH-1:0]    r_start_prim;
    logic [1:0][PRIM_AMOUNT_WIDTH-1:0]   r_num_prim;
    logic                                r_busy;
    logic                                r_done;
    logic                                r_overflow;

    logic [1:0]                          w_leaf;
    logic [1:0]                          w_inner;
    logic                                w_accept;
    logic                                w_full;
    logic                                w_empty;
    logic [c_PW-1:0]                     w_sp_dec;
    logic                                w_stack_wr;

    // A response only counts while waiting and never on a (re)start cycle.
    assign w_accept = (r_state == c_WAIT) && bus.node_valid && !bus.start;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            w_leaf[i]  = bus.child_hit[i] & bus.child_leaf[i] & (bus.child_num[i] != '0);
            w_inner[i] = bus.child_hit[i] & ~bus.child_leaf[i];
        end
    end

    assign w_full     = (r_sp == c_SP_FULL);
    assign w_empty    = (r_sp == '0);
    assign w_sp_dec   = r_sp - 1'b1;
    assign w_stack_wr = w_accept && (w_inner == 2'b11) && !w_full;

    // Stack storage needs no reset: the pointer alone defines valid entries.
    always_ff @(posedge clk) begin
        if (w_stack_wr) begin
            r_stack[r_sp[c_AW-1:0]] <= bus.child_node[1];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= c_IDLE;
            r_sp         <= '0;
            r_node_req   <= 1'b0;
            r_node_idx   <= '0;
            r_fifo_reset <= 1'b0;
            r_push       <= 1'b0;
            r_start_prim <= '0;
            r_num_prim   <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_node_req   <= 1'b0;
            r_fifo_reset <= 1'b0;
            r_push       <= 1'b0;
            r_done       <= 1'b0;
            r_start_prim <= '0;
            r_num_prim   <= '0;

            if (bus.start) begin
                r_fifo_reset <= 1'b1;
                r_node_req   <= 1'b1;
                r_node_idx   <= c_ROOT;
                r_busy       <= 1'b1;
                r_overflow   <= 1'b0;
                r_sp         <= '0;
                r_state      <= c_WAIT;
            end else if (w_accept) begin
                r_push <= |w_leaf;
                for (int i = 0; i < 2; i++) begin
                    r_start_prim[i] <= w_leaf[i] ? bus.child_start[i] : '0;
                    r_num_prim[i]   <= w_leaf[i] ? bus.child_num[i]   : '0;
                end

                case (w_inner)
                    2'b11: begin
                        r_node_req <= 1'b1;
                        r_node_idx <= bus.child_node[0];
                        if (w_full) begin
                            r_overflow <= 1'b1;
                        end else begin
                            r_sp <= r_sp + 1'b1;
                        end
                    end
                    2'b01: begin
                        r_node_req <= 1'b1;
                        r_node_idx <= bus.child_node[0];
                    end
                    2'b10: begin
                        r_node_req <= 1'b1;
                        r_node_idx <= bus.child_node[1];
                    end
                    default: begin
                        if (!w_empty) begin
                            r_node_req <= 1'b1;
                            r_node_idx <= r_stack[w_sp_dec[c_AW-1:0]];
                            r_sp       <= w_sp_dec;
                        end else begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= c_IDLE;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.node_req   = r_node_req;
    assign bus.node_idx   = r_node_idx;
    assign bus.fifo_reset = r_fifo_reset;
    assign bus.push       = r_push;
    assign bus.start_prim = r_start_prim;
    assign bus.num_prim   = r_num_prim;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.overflow   = r_overflow;

endmodule

`default_nettype wire
